// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vending controller.
package vend_pkg;

  // FSM state encoding; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CREDIT = 2'b01,
    ST_VEND   = 2'b10,
    ST_CHANGE = 2'b11
  } state_e;

  // Width of a slot index; a single-slot machine still gets a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Bus between the coin/selection front-end and the vending controller.
interface vend_ctrl_multi_if
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 8
);
  localparam int IDX_W = idx_w(NUM_ITEMS);

  // Front-end requests
  logic                          coin_valid;
  logic [CREDIT_W-1:0]           coin_value;
  logic                          sel_valid;
  logic [IDX_W-1:0]              sel_item;
  logic                          cancel;
  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat;
  logic                          restock;
  logic [IDX_W-1:0]              restock_item;

  // Controller responses
  logic                          dispense;
  logic [IDX_W-1:0]              dispense_item;
  logic                          change_valid;
  logic [CREDIT_W-1:0]           change_amt;
  logic                          coin_reject;
  logic                          sold_out;
  logic [CREDIT_W-1:0]           credit;
  state_e                        state;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_item, cancel,
           price_flat, restock, restock_item,
    input  dispense, dispense_item, change_valid, change_amt,
           coin_reject, sold_out, credit, state
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_item, cancel,
           price_flat, restock, restock_item,
    output dispense, dispense_item, change_valid, change_amt,
           coin_reject, sold_out, credit, state
  );

endinterface

// File: rtl/vend_stock_bank.sv
// Per-slot stock counters: refill on load, guarded decrement, empty flag read-out.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_FULL = 15,
  parameter int IDX_W      = idx_w(NUM_ITEMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_en,
  input  logic [IDX_W-1:0] dec_idx,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_empty
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

  // Counter update: a refill wins over a decrement of the same slot.
  // NOTE: this small counter array is reset on purpose (every slot starts full);
  // large RAM-style storage would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_FULL);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (load_en && load_idx == IDX_W'(i)) begin
          stock_q[i] <= STOCK_W'(STOCK_FULL);
        end else if (dec_en && dec_idx == IDX_W'(i) && stock_q[i] != '0) begin
          stock_q[i] <= stock_q[i] - 1'b1;
        end
      end
    end
  end

  // Empty flag of the slot being looked at; out-of-range indices read as not empty.
  always_comb begin
    rd_empty = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_empty = (stock_q[i] == '0);
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulation, vend, change and refund.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W    = 4,
  parameter int STOCK_FULL = 15
) (
  input  logic              clk,
  input  logic              rst,
  vend_ctrl_multi_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_ITEMS);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] remain_q, remain_d;   // change owed after vend, or refund
  logic [IDX_W-1:0]    item_q, item_d;
  logic                dispense_q, dispense_d;
  logic [IDX_W-1:0]    dispense_item_q, dispense_item_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sold_out_q, sold_out_d;

  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic                restock_ok;
  logic                stock_empty;
  logic [CREDIT_W:0]   sum;

  // Price mux and slot-index range checks.
  always_comb begin
    price      = '0;
    sel_ok     = 1'b0;
    restock_ok = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.sel_item == IDX_W'(i)) begin
        price  = bus.price_flat[i*CREDIT_W +: CREDIT_W];
        sel_ok = 1'b1;
      end
      if (bus.restock_item == IDX_W'(i)) restock_ok = 1'b1;
    end
  end

  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_FULL (STOCK_FULL),
    .IDX_W      (IDX_W)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .dec_en   (state_q == ST_VEND),
    .dec_idx  (item_q),
    .load_en  (bus.restock && restock_ok && state_q == ST_IDLE),
    .load_idx (bus.restock_item),
    .rd_idx   (bus.sel_item),
    .rd_empty (stock_empty)
  );

  // Next-state and registered-output logic; coin beats cancel beats select.
  // NOTE: every signal gets its default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    remain_d        = remain_q;
    item_d          = item_q;
    dispense_d      = 1'b0;
    dispense_item_d = '0;
    change_valid_d  = 1'b0;
    change_amt_d    = '0;
    coin_reject_d   = 1'b0;
    sold_out_d      = 1'b0;
    sum             = {1'b0, credit_q} + {1'b0, bus.coin_value};

    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (bus.coin_valid) begin
          if (sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = sum[CREDIT_W-1:0];
            if (sum != '0) state_d = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (bus.cancel) begin
          if (state_q == ST_CREDIT) begin
            state_d        = ST_CHANGE;
            remain_d       = credit_q;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
          end
        end else if (bus.sel_valid && sel_ok) begin
          if (stock_empty) begin
            sold_out_d = 1'b1;
          end else if (credit_q >= price) begin
            state_d         = ST_VEND;
            item_d          = bus.sel_item;
            remain_d        = credit_q - price;
            dispense_d      = 1'b1;
            dispense_item_d = bus.sel_item;
          end
        end
      end

      ST_VEND: begin
        coin_reject_d = bus.coin_valid;
        if (remain_q != '0) begin
          state_d        = ST_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = remain_q;
        end else begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end

      ST_CHANGE: begin
        coin_reject_d = bus.coin_valid;
        state_d       = ST_IDLE;
        credit_d      = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, credit and output pulse registers.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      credit_q        <= '0;
      remain_q        <= '0;
      item_q          <= '0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      change_valid_q  <= 1'b0;
      change_amt_q    <= '0;
      coin_reject_q   <= 1'b0;
      sold_out_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      remain_q        <= remain_d;
      item_q          <= item_d;
      dispense_q      <= dispense_d;
      dispense_item_q <= dispense_item_d;
      change_valid_q  <= change_valid_d;
      change_amt_q    <= change_amt_d;
      coin_reject_q   <= coin_reject_d;
      sold_out_q      <= sold_out_d;
    end
  end

  assign bus.dispense      = dispense_q;
  assign bus.dispense_item = dispense_item_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amt    = change_amt_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.sold_out      = sold_out_q;
  assign bus.credit        = credit_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi (4 slots, prices {20,25,30,100}).
module tb_vend_ctrl_multi;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vend_ctrl_multi_if #(.NUM_ITEMS(4), .CREDIT_W(8)) bus ();

  vend_ctrl_multi #(
    .NUM_ITEMS  (4),
    .CREDIT_W   (8),
    .MAX_CREDIT (100),
    .STOCK_W    (4),
    .STOCK_FULL (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       disp;
    logic [1:0] ditem;
    logic       chg_v;
    logic [7:0] chg;
    logic       rej;
    logic       so;
    logic [7:0] cr;
    logic [1:0] st;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       coin_v;
    logic [7:0] coin;
    logic       sel_v;
    logic [1:0] sel;
    logic       cancel;
    logic       restock;
    logic [1:0] rs_item;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [1:0] I = 2'b00, C = 2'b01, V = 2'b10, H = 2'b11;

  function automatic vec_t v(input string n, input logic r,
                             input logic cv, input logic [7:0] c,
                             input logic sv, input logic [1:0] s,
                             input logic cn, input logic rs, input logic [1:0] ri,
                             input logic d, input logic [1:0] di,
                             input logic chv, input logic [7:0] ch,
                             input logic rj, input logic so,
                             input logic [7:0] cr, input logic [1:0] st);
    vec_t t;
    t.name = n; t.rst = r; t.coin_v = cv; t.coin = c; t.sel_v = sv; t.sel = s;
    t.cancel = cn; t.restock = rs; t.rs_item = ri;
    t.exp = '{disp: d, ditem: di, chg_v: chv, chg: ch, rej: rj, so: so, cr: cr, st: st};
    return t;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got disp=%0b item=%0d chg_v=%0b chg=%0d rej=%0b so=%0b credit=%0d state=%0d, expected disp=%0b item=%0d chg_v=%0b chg=%0d rej=%0b so=%0b credit=%0d state=%0d",
               name, got.disp, got.ditem, got.chg_v, got.chg, got.rej, got.so, got.cr, got.st,
               exp.disp, exp.ditem, exp.chg_v, exp.chg, exp.rej, exp.so, exp.cr, exp.st);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t t);
    out_t got;
    vec_t e;
    @(negedge clk);
    rst              = t.rst;
    bus.coin_valid   = t.coin_v;
    bus.coin_value   = t.coin;
    bus.sel_valid    = t.sel_v;
    bus.sel_item     = t.sel;
    bus.cancel       = t.cancel;
    bus.restock      = t.restock;
    bus.restock_item = t.rs_item;
    sb.push_back(t);
    @(posedge clk);
    #1;
    got = '{disp: bus.dispense, ditem: bus.dispense_item, chg_v: bus.change_valid,
            chg: bus.change_amt, rej: bus.coin_reject, so: bus.sold_out,
            cr: bus.credit, st: bus.state};
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty when output arrived", t.name);
    end else begin
      e = sb.pop_front();
      check(e.name, got, e.exp);
    end
  endtask

  // Watchdog so a stuck simulation still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.coin_valid   = 1'b0;
    bus.coin_value   = '0;
    bus.sel_valid    = 1'b0;
    bus.sel_item     = '0;
    bus.cancel       = 1'b0;
    bus.restock      = 1'b0;
    bus.restock_item = '0;
    bus.price_flat   = {8'd100, 8'd30, 8'd25, 8'd20};

    //            name          rst cv coin sv sel cn rs ri | d di cv chg rj so cr st
    tbl.push_back(v("reset",      1, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("a_coin10",   0, 1, 10,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 10, C));
    tbl.push_back(v("a_coin10b",  0, 1, 10,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 20, C));
    tbl.push_back(v("a_sel0",     0, 0,  0,  1, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 20, V));
    tbl.push_back(v("a_done",     0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("b_coin50",   0, 1, 50,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 50, C));
    tbl.push_back(v("b_sel2",     0, 0,  0,  1, 2, 0, 0, 0,  1, 2, 0,  0, 0, 0, 50, V));
    tbl.push_back(v("b_change",   0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 1, 20, 0, 0, 50, H));
    tbl.push_back(v("b_idle",     0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("c_coin50",   0, 1, 50,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 50, C));
    tbl.push_back(v("c_coin45",   0, 1, 45,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 95, C));
    tbl.push_back(v("c_reject",   0, 1, 10,  0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 95, C));
    tbl.push_back(v("c_cancel",   0, 0,  0,  0, 0, 1, 0, 0,  0, 0, 1, 95, 0, 0, 95, H));
    tbl.push_back(v("c_idle",     0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("d_coin_sel", 0, 1, 25,  1, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 25, C));
    tbl.push_back(v("d_cancel",   0, 0,  0,  0, 0, 1, 0, 0,  0, 0, 1, 25, 0, 0, 25, H));
    tbl.push_back(v("d_idle",     0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("e_coin10",   0, 1, 10,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 10, C));
    tbl.push_back(v("e_sel3_low", 0, 0,  0,  1, 3, 0, 0, 0,  0, 0, 0,  0, 0, 0, 10, C));
    tbl.push_back(v("e_cancel",   0, 0,  0,  0, 0, 1, 0, 0,  0, 0, 1, 10, 0, 0, 10, H));
    tbl.push_back(v("e_idle",     0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("f_coin100",  0, 1,100,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,100, C));
    tbl.push_back(v("f_sel3",     0, 0,  0,  1, 3, 0, 0, 0,  1, 3, 0,  0, 0, 0,100, V));
    tbl.push_back(v("f_coin_vend",0, 1,  5,  0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0,  0, I));
    tbl.push_back(v("g_cancel_id",0, 0,  0,  0, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("g_coin0",    0, 1,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    tbl.push_back(v("g_coin101",  0, 1,101,  0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0,  0, I));

    foreach (tbl[k]) apply(tbl[k]);

    // Drain slot 1 (stock 15) and confirm the 16th selection reports sold out.
    for (int k = 0; k < 15; k++) begin
      apply(v("so_coin",  0, 1, 25, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 25, C));
      apply(v("so_vend",  0, 0,  0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 25, V));
      apply(v("so_idle",  0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, I));
    end
    apply(v("so_coin16",  0, 1, 25, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 25, C));
    apply(v("so_pulse",   0, 0,  0, 1, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 25, C));
    apply(v("so_refund",  0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 1, 25, 0, 0, 25, H));
    apply(v("so_idle2",   0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    apply(v("rs_restock", 0, 0,  0, 0, 0, 0, 1, 1,  0, 0, 0,  0, 0, 0,  0, I));
    apply(v("rs_coin",    0, 1, 25, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 25, C));
    apply(v("rs_vend",    0, 0,  0, 1, 1, 0, 0, 0,  1, 1, 0,  0, 0, 0, 25, V));
    apply(v("rs_idle",    0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));

    // Reset while vending discards credit and suppresses change.
    apply(v("rv_coin",    0, 1, 20, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 20, C));
    apply(v("rv_sel0",    0, 0,  0, 1, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 20, V));
    apply(v("rv_reset",   1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));
    apply(v("rv_after",   0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, I));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
